// File: rtl/config_pkg.sv
// Shared types and constants for the FU sequencer and its port mux.
// FU indices, vector addressing and the fixed-point data word.
package config_pkg;

    localparam int NumFu = 3;
    localparam int D     = 64;
    localparam int DiW   = $clog2(D);

    typedef logic [DiW-1:0]     DI_t;
    typedef logic signed [15:0] fixed_point_t;
    typedef logic [1:0]         fu_op_t;

    localparam fu_op_t FU_RMS    = 2'd0;
    localparam fu_op_t FU_MATMUL = 2'd1;
    localparam fu_op_t FU_ACT    = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_DONE
    } seq_state_t;

    function automatic logic op_legal(fu_op_t op, int n);
        return int'(op) < n;
    endfunction

endpackage

// File: rtl/vector_port_mux.sv
// Routes the host or one FU onto the shared vector memory port.
// With no owner selected, address and write enable are held at zero.
module vector_port_mux
    import config_pkg::*;
#(
    parameter int NumFu = config_pkg::NumFu
) (
    input  logic                     host_sel,
    input  logic                     fu_sel,
    input  fu_op_t                   op,
    input  DI_t [NumFu-1:0]          fu_addr,
    input  logic [NumFu-1:0]         fu_w_en,
    input  fixed_point_t [NumFu-1:0] fu_w_data,
    input  DI_t                      host_addr,
    input  logic                     host_w_en,
    input  fixed_point_t             host_w_data,
    output DI_t                      vec_addr,
    output logic                     vec_w_en,
    output fixed_point_t             vec_w_data
);

    always_comb begin
        vec_addr   = '0;
        vec_w_en   = 1'b0;
        vec_w_data = '0;
        if (host_sel) begin
            vec_addr   = host_addr;
            vec_w_en   = host_w_en;
            vec_w_data = host_w_data;
        end else if (fu_sel) begin
            for (int i = 0; i < NumFu; i++) begin
                if (op == fu_op_t'(i)) begin
                    vec_addr   = fu_addr[i];
                    vec_w_en   = fu_w_en[i];
                    vec_w_data = fu_w_data[i];
                end
            end
        end
    end

endmodule

// File: rtl/fu_sequencer.sv
// Launches one functional unit per command, tracks its busy window
// and arbitrates the shared vector port between host and the active FU.
module fu_sequencer
    import config_pkg::*;
#(
    parameter int NumFu       = config_pkg::NumFu,
    parameter int BusyTimeout = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     cmd_valid_i,
    input  fu_op_t                   cmd_op_i,
    output logic                     cmd_ready_o,
    output logic                     done_o,
    output logic                     err_o,
    output logic [31:0]              busy_cycles_o,
    input  logic [NumFu-1:0]         fu_ready_i,
    output logic [NumFu-1:0]         fu_start_o,
    input  DI_t [NumFu-1:0]          fu_addr_i,
    input  logic [NumFu-1:0]         fu_w_en_i,
    input  fixed_point_t [NumFu-1:0] fu_w_data_i,
    input  DI_t                      host_addr_i,
    input  logic                     host_w_en_i,
    input  fixed_point_t             host_w_data_i,
    output logic                     host_gnt_o,
    output DI_t                      vec_addr_o,
    output logic                     vec_w_en_o,
    output fixed_point_t             vec_w_data_o,
    input  fixed_point_t             vec_r_data_i,
    output fixed_point_t             fu_r_data_o
);

    localparam int TW = $clog2(BusyTimeout + 1);

    seq_state_t    state_q;
    fu_op_t        op_q;
    logic          err_q;
    logic [31:0]   cnt_q;
    logic [31:0]   cnt_inc;
    logic [TW-1:0] tmo_q;
    logic          sel_ready;
    logic          fu_own;

    always_comb begin
        sel_ready = 1'b0;
        for (int i = 0; i < NumFu; i++) begin
            if (op_q == fu_op_t'(i)) sel_ready = fu_ready_i[i];
        end
    end

    // Start is decoded from state so it can never outlive LAUNCH.
    always_comb begin
        fu_start_o = '0;
        for (int i = 0; i < NumFu; i++) begin
            fu_start_o[i] = (state_q == S_LAUNCH)
                          && (op_q == fu_op_t'(i))
                          && fu_ready_i[i];
        end
    end

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            op_q          <= '0;
            err_q         <= 1'b0;
            cnt_q         <= '0;
            tmo_q         <= '0;
            done_o        <= 1'b0;
            err_o         <= 1'b0;
            busy_cycles_o <= '0;
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        op_q  <= cmd_op_i;
                        cnt_q <= '0;
                        tmo_q <= '0;
                        if (op_legal(cmd_op_i, NumFu)) begin
                            err_q   <= 1'b0;
                            state_q <= S_LAUNCH;
                        end else begin
                            err_q         <= 1'b1;
                            done_o        <= 1'b1;
                            err_o         <= 1'b1;
                            busy_cycles_o <= '0;
                            state_q       <= S_DONE;
                        end
                    end
                end
                S_LAUNCH: begin
                    if (sel_ready) state_q <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (!sel_ready) begin
                        state_q <= S_WAIT_DONE;
                    end else if (tmo_q == TW'(BusyTimeout - 1)) begin
                        err_q         <= 1'b1;
                        done_o        <= 1'b1;
                        err_o         <= 1'b1;
                        busy_cycles_o <= cnt_q;
                        state_q       <= S_DONE;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                S_WAIT_DONE: begin
                    cnt_q <= cnt_inc;
                    if (sel_ready) begin
                        done_o        <= 1'b1;
                        err_o         <= err_q;
                        busy_cycles_o <= cnt_inc;
                        state_q       <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o = (state_q == S_IDLE);
    assign host_gnt_o  = (state_q == S_IDLE);
    assign fu_own      = ((state_q == S_LAUNCH)
                       || (state_q == S_WAIT_BUSY)
                       || (state_q == S_WAIT_DONE))
                       && op_legal(op_q, NumFu);
    assign fu_r_data_o = vec_r_data_i;

    vector_port_mux #(
        .NumFu(NumFu)
    ) u_mux (
        .host_sel    (host_gnt_o),
        .fu_sel      (fu_own),
        .op          (op_q),
        .fu_addr     (fu_addr_i),
        .fu_w_en     (fu_w_en_i),
        .fu_w_data   (fu_w_data_i),
        .host_addr   (host_addr_i),
        .host_w_en   (host_w_en_i),
        .host_w_data (host_w_data_i),
        .vec_addr    (vec_addr_o),
        .vec_w_en    (vec_w_en_o),
        .vec_w_data  (vec_w_data_o)
    );

endmodule

// File: tb/tb_fu_sequencer.sv
// Bench for fu_sequencer: directed table, reset-mid-op case and
// random commands against a command-level reference model.
module tb_fu_sequencer;
    import config_pkg::*;

    localparam int NF  = 3;
    localparam int TMO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                  cmd_valid;
    fu_op_t                cmd_op;
    logic                  cmd_ready, done, err, host_gnt;
    logic [31:0]           busy;
    logic [NF-1:0]         fu_ready, fu_start, fu_w_en;
    DI_t [NF-1:0]          fu_addr;
    fixed_point_t [NF-1:0] fu_w_data;
    DI_t                   host_addr, vec_addr;
    logic                  host_w_en, vec_w_en;
    fixed_point_t          host_w_data, vec_w_data, vec_r_data, fu_r_data;

    fixed_point_t mem     [D];
    fixed_point_t exp_mem [D];
    int   total = 0;
    int   bad   = 0;
    logic own_ok;

    int   low_len  [NF];
    int   remain   [NF];
    logic hold_low [NF];

    typedef struct {
        fu_op_t      op;
        int          h;
        int          l;
        logic        stall;
        fu_op_t      sop;
        int          lat;
        logic        err;
        logic [31:0] busy;
        int          starts;
    } vec_t;
    vec_t tv [6];

    fu_sequencer #(.NumFu(NF), .BusyTimeout(TMO)) dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_op_i(cmd_op),
        .cmd_ready_o(cmd_ready), .done_o(done), .err_o(err),
        .busy_cycles_o(busy),
        .fu_ready_i(fu_ready), .fu_start_o(fu_start),
        .fu_addr_i(fu_addr), .fu_w_en_i(fu_w_en), .fu_w_data_i(fu_w_data),
        .host_addr_i(host_addr), .host_w_en_i(host_w_en),
        .host_w_data_i(host_w_data), .host_gnt_o(host_gnt),
        .vec_addr_o(vec_addr), .vec_w_en_o(vec_w_en),
        .vec_w_data_o(vec_w_data), .vec_r_data_i(vec_r_data),
        .fu_r_data_o(fu_r_data)
    );

    // FU model: after a start, ready stays low for low_len cycles
    // (low_len of 0 models a unit that never goes busy).
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NF; i++) remain[i] <= 0;
        end else begin
            for (int i = 0; i < NF; i++) begin
                if (remain[i] > 0) remain[i] <= remain[i] - 1;
                else if (fu_start[i] && low_len[i] > 0) remain[i] <= low_len[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NF; i++) fu_ready[i] = !hold_low[i] && (remain[i] == 0);
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < D; i++) mem[i] <= '0;
        end else if (vec_w_en) begin
            mem[vec_addr] <= vec_w_data;
        end
    end
    assign vec_r_data = mem[vec_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic rand_ports(input logic flight);
        for (int i = 0; i < NF; i++) begin
            fu_addr[i]   = DI_t'($urandom_range(8, D - 1));
            fu_w_en[i]   = 1'($urandom_range(0, 1));
            fu_w_data[i] = fixed_point_t'($urandom);
        end
        if (flight) begin
            host_addr = DI_t'(5);
            host_w_en = 1'b1;
        end else begin
            host_addr = DI_t'($urandom_range(0, 7));
            host_w_en = 1'($urandom_range(0, 1));
        end
        host_w_data = fixed_point_t'($urandom);
    endtask

    task automatic idle_check();
        if (host_gnt !== 1'b1 || cmd_ready !== 1'b1 || done !== 1'b0
            || fu_start !== '0 || vec_w_en !== host_w_en
            || vec_addr !== host_addr || vec_w_data !== host_w_data
            || fu_r_data !== vec_r_data)
            own_ok = 1'b0;
        if (host_w_en) exp_mem[host_addr] = host_w_data;
    endtask

    // Reference: an accepted command is followed by the FU-owned cycles and
    // one DONE cycle; lat counts cycles from the accept edge to DONE.
    function automatic void ref_model(input fu_op_t op, input int h, input int l,
                                      output int lat, output logic e,
                                      output logic [31:0] b, output int s);
        if (int'(op) >= NF) begin
            lat = 1; e = 1'b1; b = 0; s = 0;
        end else if (l == 0) begin
            lat = h + 1 + TMO + 1; e = 1'b1; b = 0; s = 1;
        end else begin
            lat = h + 1 + 1 + l + 1; e = 1'b0; b = l; s = 1;
        end
    endfunction

    task automatic run_cmd(input fu_op_t op, input int h, input int l,
                           input logic stall, input fu_op_t sop,
                           output int lat, output logic e,
                           output logic [31:0] b, output int starts);
        int n;
        int idx;
        idx = int'(op);
        lat = -1; e = 1'b0; b = '0; starts = 0;
        if (idx < NF) begin
            low_len[idx]  = l;
            hold_low[idx] = (h > 0);
        end
        cmd_op    = op;
        cmd_valid = 1'b1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1; rand_ports(1'b0); #1; n++;
        end
        idle_check();
        for (n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin
                cmd_valid = stall;
                cmd_op    = stall ? sop : op;
            end
            if (idx < NF) hold_low[idx] = (n <= h);
            rand_ports(1'b1);
            #1;
            for (int i = 0; i < NF; i++) begin
                if (fu_start[i]) begin
                    starts++;
                    if (i != idx) own_ok = 1'b0;
                end
            end
            if (done === 1'b1) begin
                lat = n; e = err; b = busy;
                if (vec_w_en !== 1'b0 || vec_addr !== '0 || host_gnt !== 1'b0)
                    own_ok = 1'b0;
                break;
            end
            if (idx >= NF) begin
                own_ok = 1'b0;
            end else begin
                if (vec_w_en !== fu_w_en[idx] || vec_addr !== fu_addr[idx]
                    || vec_w_data !== fu_w_data[idx] || host_gnt !== 1'b0
                    || cmd_ready !== 1'b0 || fu_r_data !== vec_r_data)
                    own_ok = 1'b0;
                if (fu_w_en[idx]) exp_mem[fu_addr[idx]] = fu_w_data[idx];
            end
        end
    endtask

    task automatic do_cmd(input string tag, input fu_op_t op, input int h, input int l,
                          input logic stall, input fu_op_t sop,
                          input int xl, input logic xe, input logic [31:0] xb, input int xs);
        int lat;
        int starts;
        logic e;
        logic [31:0] b;
        own_ok = 1'b1;
        run_cmd(op, h, l, stall, sop, lat, e, b, starts);
        chk({tag, "_lat"}, lat, xl);
        chk({tag, "_err"}, {31'b0, e}, {31'b0, xe});
        chk({tag, "_busy"}, b, xb);
        chk({tag, "_starts"}, starts, xs);
        chk({tag, "_owner"}, {31'b0, own_ok}, 32'd1);
    endtask

    initial begin
        int xl, xs, nmis;
        logic xe;
        logic [31:0] xb;
        fu_op_t rop;
        int rh, rl;

        tv[0] = '{2'd0, 0, 20, 1'b0, 2'd0, 23, 1'b0, 32'd20, 1};
        tv[1] = '{2'd3, 0, 0,  1'b0, 2'd0, 1,  1'b1, 32'd0,  0};
        tv[2] = '{2'd1, 0, 0,  1'b0, 2'd0, 6,  1'b1, 32'd0,  1};
        tv[3] = '{2'd2, 3, 5,  1'b0, 2'd0, 11, 1'b0, 32'd5,  1};
        tv[4] = '{2'd1, 0, 1,  1'b1, 2'd2, 4,  1'b0, 32'd1,  1};
        tv[5] = '{2'd2, 0, 2,  1'b0, 2'd0, 5,  1'b0, 32'd2,  1};

        cmd_valid = 1'b0; cmd_op = '0;
        host_addr = '0; host_w_en = 1'b0; host_w_data = '0;
        fu_addr = '0; fu_w_en = '0; fu_w_data = '0;
        for (int i = 0; i < NF; i++) begin
            hold_low[i] = 1'b0;
            low_len[i]  = 0;
        end
        for (int i = 0; i < D; i++) exp_mem[i] = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_start", {29'b0, fu_start}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1; rand_ports(1'b0); #1;
        chk("rel_ready", {31'b0, cmd_ready}, 32'd1);
        chk("rel_gnt", {31'b0, host_gnt}, 32'd1);

        for (int k = 0; k < 6; k++) begin
            do_cmd($sformatf("tv%0d", k), tv[k].op, tv[k].h, tv[k].l,
                   tv[k].stall, tv[k].sop, tv[k].lat, tv[k].err,
                   tv[k].busy, tv[k].starts);
            if (k == 0) chk("mem5_kept", {16'b0, mem[5]}, {16'b0, exp_mem[5]});
        end

        // Reset in the middle of a long busy window.
        low_len[0] = 20; hold_low[0] = 1'b0;
        cmd_op = '0; cmd_valid = 1'b1;
        for (int n = 0; n < 5 && cmd_ready !== 1'b1; n++) begin
            @(posedge clk); #1; rand_ports(1'b0); #1;
        end
        @(posedge clk); #1; cmd_valid = 1'b0; rand_ports(1'b1);
        repeat (6) begin
            @(posedge clk); #1; rand_ports(1'b1);
        end
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_done", {31'b0, done}, 32'd0);
        chk("mid_rst_err", {31'b0, err}, 32'd0);
        chk("mid_rst_busy", busy, 32'd0);
        chk("mid_rst_start", {29'b0, fu_start}, 32'd0);
        chk("mid_rst_ready", {31'b0, cmd_ready}, 32'd1);
        chk("mid_rst_gnt", {31'b0, host_gnt}, 32'd1);
        @(posedge clk); #3;
        rst = 1'b0;
        host_w_en = 1'b0;
        for (int i = 0; i < D; i++) exp_mem[i] = '0;
        #1;
        chk("post_rst_ready", {31'b0, cmd_ready}, 32'd1);
        @(posedge clk); #1; rand_ports(1'b0); #1;
        do_cmd("post_rst", 2'd0, 0, 3, 1'b0, 2'd0, 6, 1'b0, 32'd3, 1);

        for (int k = 0; k < 25; k++) begin
            rop = fu_op_t'($urandom_range(0, 3));
            rh  = $urandom_range(0, 2);
            rl  = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 12);
            ref_model(rop, rh, rl, xl, xe, xb, xs);
            do_cmd($sformatf("rnd%0d", k), rop, rh, rl, 1'b0, 2'd0, xl, xe, xb, xs);
        end

        @(posedge clk); #1; host_w_en = 1'b0; #1;
        nmis = 0;
        for (int i = 0; i < D; i++) if (mem[i] !== exp_mem[i]) nmis++;
        chk("mem_image", nmis, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
